// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side companion to the LFSR pattern generator.
// It locks a local predictor onto the incoming word sequence. Once locked,
// it checks every valid word and counts word errors and bit errors.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   data_valid     data_in carries a sequence word this cycle
//   data_in        received LFSR word (WIDTH bits)
//   clear_count    synchronous clear of err_count and bit_err_count
//   locked         predictor synchronised
//   error          one-cycle pulse: last checked word mismatched while locked
//   err_count      mismatched words while locked, saturating
//   bit_err_count  mismatched bits while locked, saturating
module lfsr_checker #(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS       = 8'b10111000,
    parameter int unsigned      LOCK_COUNT = 4,
    parameter int unsigned      LOSS_COUNT = 4,
    parameter int unsigned      CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data_valid,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 clear_count,
    output logic                 locked,
    output logic                 error,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] bit_err_count
);

    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MISS_W  = $clog2(LOSS_COUNT + 1);
    localparam int unsigned PC_W    = $clog2(WIDTH + 1);
    localparam int unsigned SUM_W   = ((CNT_WIDTH > PC_W) ? CNT_WIDTH : PC_W) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     pred_q, pred_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic [MISS_W-1:0]    miss_q, miss_d;
    logic                 locked_d;
    logic                 error_d;
    logic [CNT_WIDTH-1:0] err_cnt_d;
    logic [CNT_WIDTH-1:0] bit_err_d;
    logic                 mismatch;
    logic [PC_W-1:0]      diff_bits;
    logic [SUM_W-1:0]     bit_sum;

    // One generator step: shift left, feedback parity of tapped bits into LSB.
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    assign mismatch  = (data_in != pred_q);
    assign diff_bits = popcount(data_in ^ pred_q);
    // Widened sum so an overflowing add can be detected and clamped.
    assign bit_sum   = SUM_W'(bit_err_count) + SUM_W'(diff_bits);

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        pred_d    = pred_q;
        match_d   = match_q;
        miss_d    = miss_q;
        error_d   = 1'b0;
        err_cnt_d = err_count;
        bit_err_d = bit_err_count;

        if (data_valid) begin
            case (state_q)
                HUNT: begin
                    // An all-zero word is the LFSR lockup state; never seed from it.
                    if (data_in != '0) begin
                        pred_d  = lfsr_next(data_in);
                        match_d = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    pred_d = lfsr_next(data_in);
                    if (!mismatch) begin
                        match_d = match_q + MATCH_W'(1);
                        if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                        if (data_in == '0) begin
                            state_d = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel: the predictor free-runs so bit errors are not re-seeded.
                    pred_d = lfsr_next(pred_q);
                    if (mismatch) begin
                        error_d = 1'b1;
                        if (err_count != CNT_MAX) begin
                            err_cnt_d = err_count + CNT_WIDTH'(1);
                        end
                        bit_err_d = (bit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX
                                                                : bit_sum[CNT_WIDTH-1:0];
                        if (miss_q == MISS_W'(LOSS_COUNT - 1)) begin
                            state_d = HUNT;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        // Clear wins over a same-cycle increment.
        if (clear_count) begin
            err_cnt_d = '0;
            bit_err_d = '0;
        end

        locked_d = (state_d == LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            pred_q        <= '0;
            match_q       <= '0;
            miss_q        <= '0;
            locked        <= 1'b0;
            error         <= 1'b0;
            err_count     <= '0;
            bit_err_count <= '0;
        end else begin
            state_q       <= state_d;
            pred_q        <= pred_d;
            match_q       <= match_d;
            miss_q        <= miss_d;
            locked        <= locked_d;
            error         <= error_d;
            err_count     <= err_cnt_d;
            bit_err_count <= bit_err_d;
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Testbench for lfsr_checker: two instances (default, and small saturating
// counters with a long loss count), compared each cycle against a behavioural
// model of the acquisition / flywheel / counting rules.
module tb_lfsr_checker;

    localparam int LOCK_N = 4;

    logic       clk;
    logic       rst_n;
    logic       dv0, dv1, clr0, clr1;
    logic [7:0] din0, din1;
    logic       locked0, error0, locked1, error1;
    logic [15:0] ec0, bc0;
    logic [2:0]  ec1, bc1;

    lfsr_checker dut (
        .clk(clk), .rst_n(rst_n), .data_valid(dv0), .data_in(din0),
        .clear_count(clr0), .locked(locked0), .error(error0),
        .err_count(ec0), .bit_err_count(bc0)
    );

    lfsr_checker #(.LOSS_COUNT(16), .CNT_WIDTH(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .data_valid(dv1), .data_in(din1),
        .clear_count(clr1), .locked(locked1), .error(error1),
        .err_count(ec1), .bit_err_count(bc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Generator step in arithmetic form: shift in the parity of the tapped bits.
    function automatic int tb_next(input int s);
        return ((s << 1) | ($countones(s & 8'hB8) & 1)) & 8'hFF;
    endfunction

    localparam int PH_HUNT = 0, PH_VER = 1, PH_LOCK = 2;

    typedef struct packed {
        int phase;
        int pred;
        int run;
        int miss;
        int err;
        int ec;
        int bec;
    } mdl_t;

    localparam mdl_t MDL_RESET = '{phase: PH_HUNT, default: 0};

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Reference behaviour for one clock edge.
    function automatic mdl_t mstep(input mdl_t m, input bit v, input int d,
                                   input bit clr, input int loss, input int cmax);
        int exp_w;
        m.err = 0;
        if (v) begin
            if (m.phase == PH_HUNT) begin
                if (d != 0) begin
                    m.pred = tb_next(d); m.run = 0; m.phase = PH_VER;
                end
            end else if (m.phase == PH_VER) begin
                if (d == m.pred) begin
                    m.run++;
                    m.pred = tb_next(d);
                    if (m.run == LOCK_N) begin m.phase = PH_LOCK; m.miss = 0; end
                end else begin
                    m.run = 0;
                    m.pred = tb_next(d);
                    if (d == 0) m.phase = PH_HUNT;
                end
            end else begin
                exp_w  = m.pred;
                m.pred = tb_next(m.pred);
                if (d != exp_w) begin
                    m.err = 1;
                    m.ec  = min_i(m.ec + 1, cmax);
                    m.bec = min_i(m.bec + $countones(d ^ exp_w), cmax);
                    m.miss++;
                    if (m.miss == loss) begin
                        m.phase = PH_HUNT; m.miss = 0; m.run = 0;
                    end
                end else begin
                    m.miss = 0;
                end
            end
        end
        if (clr) begin m.ec = 0; m.bec = 0; end
        return m;
    endfunction

    mdl_t m0, m1;
    int   g;

    // Drive one cycle to the selected instance (other idles), then check both.
    task automatic cycle(input bit v, input int d, input bit clr, input bit s);
        dv0  = s ? 1'b0 : v;
        clr0 = s ? 1'b0 : clr;
        dv1  = s ? v : 1'b0;
        clr1 = s ? clr : 1'b0;
        din0 = 8'(d);
        din1 = 8'(d);
        @(posedge clk);
        if (rst_n) begin
            m0 = mstep(m0, dv0, int'(din0), clr0, 4, 65535);
            m1 = mstep(m1, dv1, int'(din1), clr1, 16, 7);
        end else begin
            m0 = MDL_RESET;
            m1 = MDL_RESET;
        end
        #1;
        check("locked0", int'(locked0), int'(m0.phase == PH_LOCK));
        check("error0",  int'(error0),  m0.err);
        check("errcnt0", int'(ec0),     m0.ec);
        check("bitcnt0", int'(bc0),     m0.bec);
        check("locked1", int'(locked1), int'(m1.phase == PH_LOCK));
        check("error1",  int'(error1),  m1.err);
        check("errcnt1", int'(ec1),     m1.ec);
        check("bitcnt1", int'(bc1),     m1.bec);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (4) cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (2) cycle(1'b0, 0, 1'b0, 1'b0);
    endtask

    // Send n consecutive correct words from the current generator state.
    task automatic send_seq(input int n, input bit s);
        repeat (n) begin
            cycle(1'b1, g, 1'b0, s);
            g = tb_next(g);
        end
    endtask

    int burst;

    initial begin
        rst_n = 1'b0;
        dv0 = 1'b0; dv1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0; din0 = '0; din1 = '0;
        m0 = MDL_RESET;
        m1 = MDL_RESET;
        #2;

        // Reset values with random inputs, then quiet after release.
        do_reset();
        check("rst_locked", int'(locked0), 0);
        check("rst_errcnt", int'(ec0), 0);

        // Acquisition FF..F0, then E1, C2 clean.
        g = 8'hFF;
        send_seq(4, 1'b0);
        check("no_lock_f8", int'(locked0), 0);
        send_seq(1, 1'b0);
        check("lock_f0", int'(locked0), 1);
        check("next_e1", g, 8'hE1);
        send_seq(2, 1'b0);
        check("clean_err", int'(error0), 0);
        check("clean_ec", int'(ec0), 0);

        // Single error: E0 where E1 expected, then flywheel continues at C2.
        do_reset();
        g = 8'hFF;
        send_seq(5, 1'b0);
        cycle(1'b1, 8'hE0, 1'b0, 1'b0);
        g = tb_next(g);
        check("single_err", int'(error0), 1);
        check("single_ec", int'(ec0), 1);
        check("single_bc", int'(bc0), 1);
        check("flywheel_c2", g, 8'hC2);
        send_seq(1, 1'b0);
        check("flywheel_ok", int'(error0), 0);

        // Loss of lock: four 2-bit-corrupted words.
        cycle(1'b0, 0, 1'b1, 1'b0);
        repeat (4) begin
            cycle(1'b1, g ^ 8'h81, 1'b0, 1'b0);
            g = tb_next(g);
            check("loss_pulse", int'(error0), 1);
        end
        check("loss_ec", int'(ec0), 4);
        check("loss_bc", int'(bc0), 8);
        check("loss_unlock", int'(locked0), 0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b1, 0, 1'b0, 1'b0);
        check("zero_hunt", int'(locked0), 0);
        g = 8'hFF;
        send_seq(5, 1'b0);
        check("relock", int'(locked0), 1);

        // Gaps during acquisition, then clear on a mismatching cycle.
        do_reset();
        g = 8'hFF;
        repeat (5) begin
            cycle(1'b1, g, 1'b0, 1'b0);
            g = tb_next(g);
            repeat ($urandom_range(1, 3)) cycle(1'b0, int'($urandom_range(0, 255)), 1'b0, 1'b0);
        end
        check("gap_lock", int'(locked0), 1);
        cycle(1'b1, g ^ 8'h10, 1'b1, 1'b0);
        g = tb_next(g);
        check("clr_err", int'(error0), 1);
        check("clr_ec", int'(ec0), 0);

        // Randomized stream: gaps, corrupted words, zeros, reseeds, error bursts, clears.
        burst = 0;
        for (int it = 0; it < 2000; it++) begin
            bit v, clr;
            int w, k;
            v   = ($urandom_range(0, 99) < 75);
            clr = ($urandom_range(0, 31) == 0);
            w   = g;
            if (v) begin
                k = int'($urandom_range(0, 99));
                if (burst == 0 && $urandom_range(0, 149) == 0) burst = 5;
                if (burst > 0) begin
                    w = g ^ int'($urandom_range(1, 255));
                    burst--;
                end else if (k < 8) begin
                    w = g ^ int'($urandom_range(1, 255));
                end else if (k < 10) begin
                    w = 0;
                end else if (k < 12) begin
                    g = int'($urandom_range(1, 255));
                    w = g;
                end
                g = tb_next(g);
            end
            cycle(v, w, clr, 1'b0);
        end

        // Saturation on the 3-bit instance: 9 single-bit errors, then one more.
        do_reset();
        g = 8'hFF;
        send_seq(5, 1'b1);
        check("sat_lock", int'(locked1), 1);
        repeat (9) begin
            cycle(1'b1, g ^ 8'h01, 1'b0, 1'b1);
            g = tb_next(g);
        end
        check("sat_ec", int'(ec1), 7);
        check("sat_bc", int'(bc1), 7);
        cycle(1'b1, g ^ 8'h01, 1'b0, 1'b1);
        g = tb_next(g);
        check("sat_hold", int'(ec1), 7);
        check("sat_still_locked", int'(locked1), 1);

        // Asynchronous reset mid-stream takes effect before any clock edge.
        rst_n = 1'b0;
        #2;
        check("async_locked", int'(locked1), 0);
        check("async_ec", int'(ec1), 0);
        check("async_bc", int'(bc1), 0);
        m0 = MDL_RESET;
        m1 = MDL_RESET;
        cycle(1'b1, g, 1'b0, 1'b1);
        rst_n = 1'b1;
        g = tb_next(g);
        cycle(1'b1, g, 1'b0, 1'b1);
        check("post_rst_hunt", int'(locked1), 0);
        g = 8'hFF;
        send_seq(5, 1'b1);
        check("post_rst_lock", int'(locked1), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
